// File: rtl/sae_if.sv
// rtl/sae_if.sv - host-side request/result bundle for the sae cipher engine
interface sae_if;
  logic [1:0] mode;
  logic [7:0] data_input;
  logic [7:0] key_input;
  logic       inputs_valid;
  logic [7:0] data_output;
  logic       output_ready;
  logic       err_invalid_ptxt_char;
  logic       err_invalid_seckey;
  logic       err_invalid_ctxt_char;

  modport master (
    output mode, data_input, key_input, inputs_valid,
    input  data_output, output_ready,
    input  err_invalid_ptxt_char, err_invalid_seckey, err_invalid_ctxt_char
  );

  modport slave (
    input  mode, data_input, key_input, inputs_valid,
    output data_output, output_ready,
    output err_invalid_ptxt_char, err_invalid_seckey, err_invalid_ctxt_char
  );
endinterface

// File: rtl/sae.sv
// rtl/sae.sv - one-byte modular cipher: keygen/encrypt/decrypt, registered result
// Optional SAE_INPUT_REG_EN adds an input register stage (latency 2, same throughput).
module sae #(
  parameter logic [7:0] N = 8'd227
) (
  input  logic  clk,
  input  logic  rst_n,
  sae_if.slave  bus
);

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_KEYGEN = 2'b01;
  localparam logic [1:0] MODE_ENC    = 2'b10;
  localparam logic [1:0] MODE_DEC    = 2'b11;

  logic [1:0] mode_s;
  logic [7:0] data_s;
  logic [7:0] key_s;
  logic       valid_s;

`ifdef SAE_INPUT_REG_EN
  logic [1:0] mode_q;
  logic [7:0] data_q;
  logic [7:0] key_q;
  logic       valid_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      mode_q  <= MODE_IDLE;
      data_q  <= 8'd0;
      key_q   <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= bus.mode;
      data_q  <= bus.data_input;
      key_q   <= bus.key_input;
      valid_q <= bus.inputs_valid;
    end
  end

  assign mode_s  = mode_q;
  assign data_s  = data_q;
  assign key_s   = key_q;
  assign valid_s = valid_q;
`else
  assign mode_s  = bus.mode;
  assign data_s  = bus.data_input;
  assign key_s   = bus.key_input;
  assign valid_s = bus.inputs_valid;
`endif

  logic       accept;
  logic       key_bad;
  logic       char_bad;
  logic [8:0] sum;
  logic [8:0] sum_mod;

  logic [7:0] dout_d, dout_q;
  logic       ready_d, ready_q;
  logic       err_p_d, err_p_q;
  logic       err_k_d, err_k_q;
  logic       err_c_d, err_c_q;

  assign accept   = valid_s && (mode_s != MODE_IDLE);
  assign key_bad  = (key_s == 8'd0) || (key_s >= N);
  assign char_bad = (data_s >= N);
  // Both operands are below N, so one conditional subtract closes the wrap.
  assign sum      = {1'b0, data_s} + {1'b0, key_s};
  assign sum_mod  = (sum >= {1'b0, N}) ? (sum - {1'b0, N}) : sum;

  always_comb begin
    dout_d  = dout_q;
    ready_d = accept;
    err_p_d = err_p_q;
    err_k_d = err_k_q;
    err_c_d = err_c_q;
    if (accept) begin
      err_k_d = key_bad;
      err_p_d = (mode_s == MODE_ENC) && char_bad;
      err_c_d = (mode_s == MODE_DEC) && char_bad;
      unique case (mode_s)
        MODE_KEYGEN: dout_d = key_bad ? 8'd0 : (N - key_s);
        MODE_ENC,
        MODE_DEC:    dout_d = (key_bad || char_bad) ? 8'd0 : sum_mod[7:0];
        default:     dout_d = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      dout_q  <= 8'd0;
      ready_q <= 1'b0;
      err_p_q <= 1'b0;
      err_k_q <= 1'b0;
      err_c_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      ready_q <= ready_d;
      err_p_q <= err_p_d;
      err_k_q <= err_k_d;
      err_c_q <= err_c_d;
    end
  end

  assign bus.data_output           = dout_q;
  assign bus.output_ready          = ready_q;
  assign bus.err_invalid_ptxt_char = err_p_q;
  assign bus.err_invalid_seckey    = err_k_q;
  assign bus.err_invalid_ctxt_char = err_c_q;

endmodule

// File: tb/tb_sae.sv
// tb/tb_sae.sv - directed self-checking bench for sae (default build, latency 1)
module tb_sae;
  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  sae_if bus ();

  sae u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, then sample 1ns after the rising edge.
  task automatic step(input logic r, input logic [1:0] m, input logic [7:0] d,
                      input logic [7:0] k, input logic v);
    @(negedge clk);
    rst_n            = r;
    bus.mode         = m;
    bus.data_input   = d;
    bus.key_input    = k;
    bus.inputs_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int rdy, input int dout,
                            input int ep, input int ek, input int ec);
    check({tag, ".ready"}, int'(bus.output_ready), rdy);
    check({tag, ".data"},  int'(bus.data_output), dout);
    check({tag, ".err_p"}, int'(bus.err_invalid_ptxt_char), ep);
    check({tag, ".err_k"}, int'(bus.err_invalid_seckey), ek);
    check({tag, ".err_c"}, int'(bus.err_invalid_ctxt_char), ec);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b1;
    bus.mode = 2'b00; bus.data_input = 8'd0; bus.key_input = 8'd0; bus.inputs_valid = 1'b0;

    step(1'b1, 2'b01, 8'd0, 8'd5, 1'b1);
    step(1'b1, 2'b01, 8'd0, 8'd5, 1'b1);
    expect_out("reset", 0, 0, 0, 0, 0);

    step(1'b0, 2'b01, 8'd0, 8'd5, 1'b1);
    expect_out("keygen5", 1, 222, 0, 0, 0);
    step(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    expect_out("idle_hold", 0, 222, 0, 0, 0);

    step(1'b0, 2'b10, 8'd100, 8'd222, 1'b1);
    expect_out("enc100", 1, 95, 0, 0, 0);
    step(1'b0, 2'b11, 8'd95, 8'd5, 1'b1);
    expect_out("dec95", 1, 100, 0, 0, 0);

    step(1'b0, 2'b01, 8'd0, 8'd0, 1'b1);
    expect_out("keygen0", 1, 0, 0, 1, 0);
    step(1'b0, 2'b01, 8'd0, 8'd227, 1'b1);
    expect_out("keygen227", 1, 0, 0, 1, 0);
    step(1'b0, 2'b01, 8'd0, 8'd226, 1'b1);
    expect_out("keygen226", 1, 1, 0, 0, 0);
    step(1'b0, 2'b01, 8'd0, 8'd1, 1'b1);
    expect_out("keygen1", 1, 226, 0, 0, 0);

    step(1'b0, 2'b10, 8'd230, 8'd0, 1'b1);
    expect_out("enc_botherr", 1, 0, 1, 1, 0);
    step(1'b0, 2'b11, 8'd255, 8'd5, 1'b1);
    expect_out("dec_ctxterr", 1, 0, 0, 0, 1);

    step(1'b0, 2'b10, 8'd226, 8'd226, 1'b1);
    expect_out("enc_max", 1, 225, 0, 0, 0);
    step(1'b0, 2'b10, 8'd1, 8'd226, 1'b1);
    expect_out("enc_sumN", 1, 0, 0, 0, 0);
    step(1'b0, 2'b10, 8'd0, 8'd5, 1'b1);
    expect_out("enc_char0", 1, 5, 0, 0, 0);
    step(1'b0, 2'b11, 8'd227, 8'd5, 1'b1);
    expect_out("dec_char227", 1, 0, 0, 0, 1);

    step(1'b0, 2'b01, 8'd0, 8'd10, 1'b1);
    expect_out("b2b_1", 1, 217, 0, 0, 0);
    step(1'b0, 2'b10, 8'd3, 8'd217, 1'b1);
    expect_out("b2b_2", 1, 220, 0, 0, 0);
    step(1'b0, 2'b11, 8'd220, 8'd10, 1'b1);
    expect_out("b2b_3", 1, 3, 0, 0, 0);
    step(1'b0, 2'b00, 8'd50, 8'd50, 1'b1);
    expect_out("b2b_idle", 0, 3, 0, 0, 0);

    step(1'b0, 2'b01, 8'd0, 8'd20, 1'b1);
    expect_out("pre_rst", 1, 207, 0, 0, 0);
    step(1'b1, 2'b01, 8'd0, 8'd0, 1'b1);
    expect_out("mid_rst", 0, 0, 0, 0, 0);
    step(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    expect_out("post_rst", 0, 0, 0, 0, 0);
    step(1'b0, 2'b00, 8'd7, 8'd7, 1'b1);
    expect_out("idle_valid", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
